// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA text-mode UART command link.
package vga_pkg;

  localparam int N_COL         = 80;
  localparam int N_ROW         = 30;
  localparam int N_COL_WIDTH   = 7;
  localparam int N_ROW_WIDTH   = 5;
  localparam int N_CHARS_WIDTH = 7;

  localparam logic [7:0] EOL_BYTE = 8'h0A;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 serializer with baud counter; a new byte may be loaded in the last
// stop-bit cycle so consecutive bytes go out with no idle gap.
module uart_tx_byte
  import vga_pkg::*;
#(
  parameter int DIV = 217
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       tx,
  output logic       done,
  output state_t     state
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_end;
  logic          load;

  // Handshake: a byte is taken on the edge where byte_valid && byte_ready.
  assign bit_end    = (cnt == LAST);
  assign done       = (state == STOP) && bit_end;
  assign byte_ready = (state == IDLE) || done;
  assign load       = byte_valid && byte_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else if (load) begin
      state   <= START;
      tx      <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= byte_data;
    end else begin
      case (state)
        IDLE: begin
          tx  <= 1'b1;
          cnt <= '0;
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
            tx    <= shreg[0];
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              // shreg[0] is on the line; shift so the next bit sits at [0]
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[1];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_tx.sv
// Frame sequencer: sends {col, row, char, 0x0A} as four back-to-back 8N1 bytes.
// Optional RANGE_CHECK_EN drops out-of-range commands and pulses err_o.
module uart_cmd_tx #(
  parameter int CLK_FREQ      = 25000000,
  parameter int BAUD_RATE     = 115200,
  parameter int N_COL_WIDTH   = vga_pkg::N_COL_WIDTH,
  parameter int N_ROW_WIDTH   = vga_pkg::N_ROW_WIDTH,
  parameter int N_CHARS_WIDTH = vga_pkg::N_CHARS_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [N_COL_WIDTH-1:0]   col_i,
  input  logic [N_ROW_WIDTH-1:0]   row_i,
  input  logic [N_CHARS_WIDTH-1:0] char_i,
  output logic                     tx_o,
  output logic                     busy_o,
  output logic                     frame_done_o,
  output logic                     err_o
);
  import vga_pkg::*;

  localparam int DIV = CLK_FREQ / BAUD_RATE;

  state_t                   tx_state;
  logic                     busy, accept, range_bad, start_frame;
  logic                     byte_valid, byte_ready, byte_done;
  logic [7:0]               byte_data, next_byte;
  logic [1:0]               byte_idx;
  logic [N_ROW_WIDTH-1:0]   row_q;
  logic [N_CHARS_WIDTH-1:0] char_q;

  assign busy        = (tx_state != IDLE);
  assign busy_o      = busy;
  assign cmd_ready_o = !busy && !rst_i;
  assign accept      = cmd_valid_i && cmd_ready_o;

`ifdef RANGE_CHECK_EN
  assign range_bad = (int'(col_i) >= N_COL) || (int'(row_i) >= N_ROW);
`else
  assign range_bad = 1'b0;
`endif

  assign start_frame = accept && !range_bad;

  // byte_idx is the byte on the line; the serializer pre-loads idx+1.
  always_comb begin
    next_byte = EOL_BYTE;
    case (byte_idx)
      2'd0:    next_byte = 8'(row_q);
      2'd1:    next_byte = 8'(char_q);
      default: next_byte = EOL_BYTE;
    endcase
  end

  // Column goes straight from the input into the serializer on accept.
  assign byte_data  = busy ? next_byte : 8'(col_i);
  assign byte_valid = start_frame || (busy && (byte_idx != 2'd3));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      byte_idx     <= '0;
      row_q        <= '0;
      char_q       <= '0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= busy && byte_done && (byte_idx == 2'd3);
      if (start_frame) begin
        byte_idx <= '0;
        row_q    <= row_i;
        char_q   <= char_i;
      end else if (busy && byte_valid && byte_ready) begin
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

`ifdef RANGE_CHECK_EN
  logic err_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= accept && range_bad;
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  uart_tx_byte #(
    .DIV(DIV)
  ) u_ser (
    .clk       (clk_i),
    .rst       (rst_i),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .tx        (tx_o),
    .done      (byte_done),
    .state     (tx_state)
  );

endmodule

// File: tb/tb_uart_cmd_tx.sv
// Bench for uart_cmd_tx: per-cycle waveform reference model plus a table of
// commands decoded by a mid-bit UART receiver, with directed corner cases.
module tb_uart_cmd_tx;

  localparam int CLK_FREQ = 25000000;
  localparam int BAUD     = 1562500;
  localparam int DIV      = CLK_FREQ / BAUD;  // 16 cycles per bit

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [6:0] col = '0;
  logic [4:0] row = '0;
  logic [6:0] chr = '0;
  logic       cmd_ready_o, tx_o, busy_o, frame_done_o, err_o;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  uart_cmd_tx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready_o),
    .col_i       (col),
    .row_i       (row),
    .char_i      (chr),
    .tx_o        (tx_o),
    .busy_o      (busy_o),
    .frame_done_o(frame_done_o),
    .err_o       (err_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected tx levels for a whole frame, one entry per clock cycle.
  bit wave_q[$];
  bit m_valid = 0, m_busy = 0, m_tx = 1, m_done = 0, m_err = 0;

  function automatic bit range_bad(input logic [6:0] c, input logic [4:0] r);
`ifdef RANGE_CHECK_EN
    return (c >= 7'd80) || (r >= 5'd30);
`else
    return 1'b0;
`endif
  endfunction

  task automatic build_frame(input logic [7:0] b0, b1, b2, b3);
    logic [7:0] bytes [4];
    bytes = '{b0, b1, b2, b3};
    for (int k = 0; k < 4; k++) begin
      repeat (DIV) wave_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) repeat (DIV) wave_q.push_back(bytes[k][i]);
      repeat (DIV) wave_q.push_back(1'b1);
    end
  endtask

  always @(posedge clk) begin
    m_done = 0;
    m_err  = 0;
    if (rst) begin
      wave_q.delete();
      m_busy  = 0;
      m_tx    = 1;
      m_valid = 1;
    end else if (m_valid) begin
      if (m_busy && wave_q.size() == 0) begin
        m_busy = 0;
        m_done = 1;
        m_tx   = 1;
      end else if (m_busy) begin
        m_tx = wave_q.pop_front();
      end else if (cmd_valid) begin
        if (range_bad(col, row)) begin
          m_err = 1;
        end else begin
          build_frame({1'b0, col}, {3'b000, row}, {1'b0, chr}, 8'h0A);
          m_busy = 1;
          m_tx   = wave_q.pop_front();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("tx_o", tx_o, m_tx);
      check("busy_o", busy_o, m_busy);
      check("cmd_ready_o", cmd_ready_o, !rst && !m_busy);
      check("frame_done_o", frame_done_o, m_done);
      check("err_o", err_o, m_err);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [6:0] c, input logic [4:0] r, input logic [6:0] ch,
                          input bit hold);
    int t = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; col = c; row = r; chr = ch;
    @(negedge clk);
    while (cmd_ready_o !== 1'b1 && t < 60 * DIV) begin
      @(negedge clk);
      t++;
    end
    check("accept_wait", (cmd_ready_o === 1'b1), 1);
    @(posedge clk); #1;
    if (!hold) begin
      cmd_valid = 1'b0;
      col = 7'($urandom); row = 5'($urandom); chr = 7'($urandom);
    end
  endtask

  task automatic recv_byte(output logic [7:0] b, output bit ok, output int t_start);
    int t = 0;
    b = '0; ok = 0; t_start = 0;
    do begin
      @(negedge clk);
      t++;
    end while (tx_o !== 1'b0 && t < 4 * DIV);
    if (tx_o !== 1'b0) return;
    t_start = cyc;
    repeat (DIV / 2) @(negedge clk);
    if (tx_o !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      repeat (DIV) @(negedge clk);
      b[i] = tx_o;
    end
    repeat (DIV) @(negedge clk);
    ok = (tx_o === 1'b1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((m_busy || cmd_valid) && t < 60 * DIV) begin
      @(negedge clk);
      t++;
    end
    check("idle_wait", m_busy, 0);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [6:0]  col;
    logic [4:0]  row;
    logic [6:0]  ch;
    logic [31:0] exp_bytes;
  } vec_t;

  logic [7:0] exp_q[$];

  task automatic run_vec(input vec_t v);
    logic [7:0] b;
    bit         ok;
    int         ts, t0, t;
    for (int k = 0; k < 4; k++) exp_q.push_back(v.exp_bytes[31 - 8 * k -: 8]);
    send_cmd(v.col, v.row, v.ch, 1'b0);
    t0 = 0;
    for (int k = 0; k < 4; k++) begin
      recv_byte(b, ok, ts);
      if (k == 0) t0 = ts;
      check("stop_bit", ok, 1);
      check("frame_byte", b, exp_q.pop_front());
    end
    t = 0;
    while (frame_done_o !== 1'b1 && t < 4 * DIV) begin
      @(negedge clk);
      t++;
    end
    check("done_latency", cyc - t0, 40 * DIV);
    wait_idle();
  endtask

  // ---------------- test sequence ----------------
  vec_t tbl[$];

  initial begin
    tbl.push_back('{7'd5,   5'd3,  7'h41, 32'h0503410A});
    tbl.push_back('{7'd79,  5'd29, 7'h7E, 32'h4F1D7E0A});
    tbl.push_back('{7'd0,   5'd0,  7'h20, 32'h0000200A});
    tbl.push_back('{7'd10,  5'd2,  7'h48, 32'h0A02480A});
    tbl.push_back('{7'd127, 5'd31, 7'h55, 32'h7F1F550A});
`ifndef RANGE_CHECK_EN
    tbl.push_back('{7'd80,  5'd0,  7'h5A, 32'h50005A0A});
`endif

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_tx", tx_o, 1);
    check("reset_busy", busy_o, 0);
    check("reset_ready", cmd_ready_o, 1);
    check("reset_done", frame_done_o, 0);
    check("reset_err", err_o, 0);

    foreach (tbl[i]) run_vec(tbl[i]);

    // Back-to-back: valid stays high across two commands.
    begin
      int t = 0;
      send_cmd(7'd79, 5'd29, 7'h7E, 1'b1);
      col = 7'd0; row = 5'd0; chr = 7'h20;
      while (frame_done_o !== 1'b1 && t < 50 * DIV) begin
        @(negedge clk);
        t++;
      end
      check("b2b_gap_tx", tx_o, 1);
      @(negedge clk);
      check("b2b_start_tx", tx_o, 0);
      check("b2b_busy", busy_o, 1);
      @(posedge clk); #1 cmd_valid = 1'b0;
      wait_idle();
    end

    // Reset in the middle of a frame, then a fresh frame.
    send_cmd(7'd33, 5'd7, 7'h61, 1'b0);
    repeat (300) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_ready_in_rst", cmd_ready_o, 0);
    @(negedge clk);
    check("midrst_tx", tx_o, 1);
    check("midrst_busy", busy_o, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_ready_after", cmd_ready_o, 1);
    run_vec('{7'd12, 5'd9, 7'h3F, 32'h0C093F0A});

`ifdef RANGE_CHECK_EN
    begin
      int lows = 0;
      send_cmd(7'd80, 5'd0, 7'h5A, 1'b0);
      @(negedge clk);
      check("range_err_pulse", err_o, 1);
      repeat (100) begin
        @(negedge clk);
        if (tx_o !== 1'b1) lows++;
      end
      check("range_tx_quiet", lows, 0);
    end
`endif

    // Randomized commands with random gaps, checked by the waveform model.
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send_cmd(7'($urandom_range(0, 127)), 5'($urandom_range(0, 31)),
               7'($urandom_range(0, 127)), 1'b0);
      wait_idle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
